// File: rtl/alu_result_fifo.sv
// Result buffer behind the demo ALU: captures {op, r} pairs in a circular FIFO
// and hands them to the consumer over valid/ready, flagging dropped results.
module alu_result_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_r,
  input  logic [OP_W-1:0]          in_op,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_r,
  output logic [OP_W-1:0]          out_op,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         accepted,
  input  logic                     clr_flags
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = OP_W + DATA_W;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] accepted_q, accepted_d;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;
  logic [EW-1:0]    head_s;

  // Handshake decode and next-state computation.
  always_comb begin
    full_s  = (level_q == LW'(DEPTH));
    empty_s = (level_q == {LW{1'b0}});
    push_s  = in_valid && !full_s;
    pop_s   = out_ready && !empty_s;
    drop_s  = in_valid && full_s;

    wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A drop on the same edge as a clear keeps the flag set.
    overflow_d = drop_s | (overflow_q & ~clr_flags);

    if (push_s) begin
      accepted_d = (clr_flags ? {CNT_W{1'b0}} : accepted_q) + CNT_W'(1);
    end else begin
      accepted_d = clr_flags ? {CNT_W{1'b0}} : accepted_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      level_q    <= {LW{1'b0}};
      overflow_q <= 1'b0;
      accepted_q <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      accepted_q <= accepted_d;
    end
  end

  // Entry storage; stale contents are harmless because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_op, in_r};
    end
  end

  // Head presentation, masked to zero while empty.
  always_comb begin
    head_s    = mem_q[rd_ptr_q];
    in_ready  = !full_s;
    out_valid = !empty_s;
    if (out_valid) begin
      out_r  = head_s[DATA_W-1:0];
      out_op = head_s[EW-1:DATA_W];
    end else begin
      out_r  = {DATA_W{1'b0}};
      out_op = {OP_W{1'b0}};
    end
    out_zero = out_valid && (out_r == {DATA_W{1'b0}});
    level    = level_q;
    overflow = overflow_q;
    accepted = accepted_q;
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomised bench for alu_result_fifo, checked against a queue-based model
// of the FIFO, its sticky overflow flag and accepted counter.
module tb_alu_result_fifo;

  typedef logic [58:0] vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_r = 32'h0;
  logic [2:0]  in_op = 3'h0;
  logic        out_ready = 1'b0;
  logic        clr_flags = 1'b0;
  logic        in_ready, out_valid, out_zero, overflow;
  logic [31:0] out_r;
  logic [2:0]  out_op;
  logic [3:0]  level;
  logic [15:0] accepted;

  logic        v4 = 1'b0;
  logic        rdy4 = 1'b0;
  logic        in_ready4, out_valid4, out_zero4, overflow4;
  logic [31:0] out_r4;
  logic [2:0]  out_op4;
  logic [3:0]  level4;
  logic [3:0]  accepted4;

  int vectors = 0;
  int errors  = 0;

  logic [34:0] mq[$];
  logic        ov_m = 1'b0;
  logic [15:0] acc_m = 16'h0;

  vec_t obs_s;
  assign obs_s = {out_valid, out_op, out_r, out_zero, level, in_ready, overflow, accepted};

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(8), .DATA_W(32), .OP_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_r(in_r), .in_op(in_op),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_op(out_op), .out_zero(out_zero), .level(level),
    .overflow(overflow), .accepted(accepted), .clr_flags(clr_flags)
  );

  alu_result_fifo #(.DEPTH(8), .DATA_W(32), .OP_W(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_r(32'h0000_00A5), .in_op(3'h2),
    .in_ready(in_ready4), .out_valid(out_valid4), .out_ready(rdy4),
    .out_r(out_r4), .out_op(out_op4), .out_zero(out_zero4), .level(level4),
    .overflow(overflow4), .accepted(accepted4), .clr_flags(1'b0)
  );

  function automatic vec_t exp_vec();
    logic        v;
    logic [31:0] r;
    logic [2:0]  op;
    v  = (mq.size() != 0);
    r  = v ? mq[0][31:0]  : 32'h0;
    op = v ? mq[0][34:32] : 3'h0;
    return {v, op, r, (v && r == 32'h0), 4'(mq.size()), (mq.size() != 8), ov_m, acc_m};
  endfunction

  task automatic model_reset();
    mq.delete();
    ov_m  = 1'b0;
    acc_m = 16'h0;
  endtask

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic cycle();
    bit full, push, pop;
    full = (mq.size() == 8);
    push = in_valid && !full;
    pop  = out_ready && (mq.size() != 0);
    if (in_valid && full) ov_m = 1'b1;
    else if (clr_flags)   ov_m = 1'b0;
    if (clr_flags) acc_m = 16'h0;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back({in_op, in_r});
      acc_m = acc_m + 16'h1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic [2:0] op,
                       input logic rdy, input logic clr);
    in_valid  = v;
    in_r      = r;
    in_op     = op;
    out_ready = rdy;
    clr_flags = clr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    vectors++;
    if (obs_s !== exp_vec()) begin
      errors++;
      $display("FAIL reset: got %h exp %h", obs_s, exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    vectors++;
    if (obs_s !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release: got %h exp %h", obs_s, exp_vec());
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 32'h5, 3'd1, 1'b0, 1'b0);
    cycle();
    vectors++;
    if (out_valid !== 1'b1 || out_r !== 32'h5 || out_op !== 3'd1 || out_zero !== 1'b0) begin
      errors++;
      $display("FAIL basic_first: got v=%b r=%h op=%0d z=%b exp v=1 r=5 op=1 z=0",
               out_valid, out_r, out_op, out_zero);
    end
    drive(1'b1, 32'h0, 3'd3, 1'b0, 1'b0);
    cycle();
    vectors++;
    if (level !== 4'd2 || obs_s !== exp_vec()) begin
      errors++;
      $display("FAIL basic_level: got %h exp %h", obs_s, exp_vec());
    end
    drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
    cycle();
    vectors++;
    if (out_r !== 32'h0 || out_op !== 3'd3 || out_zero !== 1'b1 || obs_s !== exp_vec()) begin
      errors++;
      $display("FAIL basic_pop: got r=%h op=%0d z=%b exp r=0 op=3 z=1", out_r, out_op, out_zero);
    end
  endtask

  task automatic test_drain(input string tag);
    drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10 && mq.size() != 0; i++) begin
      cycle();
      vectors++;
      if (obs_s !== exp_vec()) begin
        errors++;
        $display("FAIL drain_%s: got %h exp %h", tag, obs_s, exp_vec());
      end
    end
    vectors++;
    if (out_valid !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL drain_%s_empty: got v=%b level=%0d exp v=0 level=0", tag, out_valid, level);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    cycle();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h10 + 32'(i), 3'($urandom_range(7)), 1'b0, 1'b0);
      cycle();
    end
    vectors++;
    if (level !== 4'd8 || in_ready !== 1'b0 || obs_s !== exp_vec()) begin
      errors++;
      $display("FAIL overflow_full: got %h exp %h", obs_s, exp_vec());
    end
    drive(1'b1, 32'h18, 3'd0, 1'b0, 1'b0);
    cycle();
    vectors++;
    if (overflow !== 1'b1 || accepted !== 16'd8 || obs_s !== exp_vec()) begin
      errors++;
      $display("FAIL overflow_drop: got ov=%b acc=%0d exp ov=1 acc=8", overflow, accepted);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (out_r !== 32'h10 + 32'(i)) begin
        errors++;
        $display("FAIL overflow_order: got %h exp %h", out_r, 32'h10 + 32'(i));
      end
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      cycle();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] d;
    logic [2:0]  op;
    for (int i = 0; i < 20; i++) begin
      d  = $urandom;
      op = 3'($urandom_range(7));
      drive(1'b1, d, op, 1'b1, 1'b0);
      cycle();
      vectors++;
      if (level !== 4'd1 || out_r !== d || out_op !== op || obs_s !== exp_vec()) begin
        errors++;
        $display("FAIL stream %0d: got level=%0d r=%h op=%0d exp level=1 r=%h op=%0d",
                 i, level, out_r, out_op, d, op);
      end
    end
    test_drain("stream");
  endtask

  task automatic test_full_popdrop();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, $urandom, 3'($urandom_range(7)), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 32'hDEAD_BEEF, 3'd7, 1'b1, 1'b0);
    cycle();
    vectors++;
    if (overflow !== 1'b1 || level !== 4'd7 || obs_s !== exp_vec()) begin
      errors++;
      $display("FAIL popdrop: got ov=%b level=%0d exp ov=1 level=7", overflow, level);
    end
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    cycle();
    vectors++;
    if (overflow !== 1'b0 || accepted !== 16'd0 || level !== 4'd7 || obs_s !== exp_vec()) begin
      errors++;
      $display("FAIL popdrop_clr: got ov=%b acc=%0d level=%0d exp ov=0 acc=0 level=7",
               overflow, accepted, level);
    end
    clr_flags = 1'b0;
    test_drain("popdrop");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(9) < 7), $urandom & (($urandom_range(3) == 0) ? 32'h0 : 32'hFFFF_FFFF),
            3'($urandom_range(7)), ($urandom_range(1) == 1), ($urandom_range(19) == 0));
      cycle();
      vectors++;
      if (obs_s !== exp_vec()) begin
        errors++;
        $display("FAIL random %0d: got %h exp %h", i, obs_s, exp_vec());
      end
    end
    clr_flags = 1'b0;
    test_drain("random");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 3'd4, 1'b0, 1'b0);
      cycle();
    end
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || level !== 4'd0 || in_ready !== 1'b1 || obs_s !== exp_vec()) begin
      errors++;
      $display("FAIL async_reset: got v=%b level=%0d rdy=%b exp v=0 level=0 rdy=1",
               out_valid, level, in_ready);
    end
    #2;
    rst_n = 1'b1;
    cycle();
    drive(1'b1, 32'h0000_ABCD, 3'd5, 1'b0, 1'b0);
    cycle();
    in_valid = 1'b0;
    vectors++;
    if (out_r !== 32'h0000_ABCD || out_op !== 3'd5 || level !== 4'd1 || obs_s !== exp_vec()) begin
      errors++;
      $display("FAIL async_readback: got r=%h op=%0d level=%0d exp r=0000abcd op=5 level=1",
               out_r, out_op, level);
    end
    test_drain("async");
  endtask

  task automatic test_counter_wrap();
    v4   = 1'b1;
    rdy4 = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk);
      #1;
      if (i >= 15) begin
        vectors++;
        if (accepted4 !== 4'(i % 16)) begin
          errors++;
          $display("FAIL counter_wrap %0d: got %0d exp %0d", i, accepted4, i % 16);
        end
      end
    end
    v4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drain("basic");
    test_overflow();
    test_stream();
    test_full_popdrop();
    test_random();
    test_async_reset();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
